// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider, 16-bit by 8-bit, one quotient bit per clock
//
// Ports:
//   CLK        system clock, all state changes on posedge
//   RESET_N    asynchronous active-low reset
//   START      level request, acted on only while idle
//   DIVIDEND   dividend operand, captured on the accepted START edge
//   DIVISOR    divisor operand, captured on the accepted START edge
//   QUOTIENT   registered quotient (all ones on divide-by-zero)
//   REMAINDER  registered remainder (all ones on divide-by-zero)
//   BUSY       high while a division is in flight (CALC or POST)
//   DONE       one-cycle pulse when a result or error is posted
//   DIVERR     divide-by-zero flag for the last accepted operation
module seq_divider #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  START,
  input  logic [DIVIDEND_W-1:0] DIVIDEND,
  input  logic [DIVISOR_W-1:0]  DIVISOR,
  output logic [DIVIDEND_W-1:0] QUOTIENT,
  output logic [DIVISOR_W-1:0]  REMAINDER,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  DIVERR
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_POST = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      count;
  logic [DIVIDEND_W-1:0] dvd_shift;
  logic [DIVISOR_W-1:0]  dvsr;
  // The stored partial remainder is always < divisor, so DIVISOR_W bits hold
  // it; only the shifted trial value needs the extra bit.
  logic [DIVISOR_W-1:0]  partial;
  logic [DIVISOR_W:0]    trial;
  logic [DIVISOR_W-1:0]  trial_diff;
  logic                  qbit;
  logic                  start_ok;
  logic                  start_zero;

  assign start_ok   = START && (DIVISOR != '0);
  assign start_zero = START && (DIVISOR == '0);

  // Restoring step: shift in the next dividend bit, subtract if it fits.
  // The difference is below the divisor when taken, so the low bits suffice.
  always_comb begin
    trial      = {partial, dvd_shift[DIVIDEND_W-1]};
    qbit       = (trial >= {1'b0, dvsr});
    trial_diff = trial[DIVISOR_W-1:0] - dvsr;
  end

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_ok) state_nxt = S_CALC;
      // Leave on the iteration that takes the counter from 1 to 0.
      S_CALC: if (count == CNT_W'(1)) state_nxt = S_POST;
      S_POST: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    BUSY = (state != S_IDLE);
  end

  // Datapath and registered results
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count     <= '0;
      dvd_shift <= '0;
      dvsr      <= '0;
      partial   <= '0;
      QUOTIENT  <= '0;
      REMAINDER <= '0;
      DONE      <= 1'b0;
      DIVERR    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            dvd_shift <= DIVIDEND;
            dvsr      <= DIVISOR;
            partial   <= '0;
            count     <= CNT_W'(DIVIDEND_W);
            DIVERR    <= 1'b0;
          end else if (start_zero) begin
            QUOTIENT  <= '1;
            REMAINDER <= '1;
            DIVERR    <= 1'b1;
            DONE      <= 1'b1;
          end
        end
        S_CALC: begin
          partial   <= qbit ? trial_diff : trial[DIVISOR_W-1:0];
          dvd_shift <= {dvd_shift[DIVIDEND_W-2:0], qbit};
          count     <= count - CNT_W'(1);
        end
        S_POST: begin
          QUOTIENT  <= dvd_shift;
          REMAINDER <= partial;
          DONE      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed and swept self-checking bench for seq_divider
module tb_seq_divider;

  logic        CLK;
  logic        RESET_N;
  logic        START;
  logic [15:0] DIVIDEND;
  logic [7:0]  DIVISOR;
  logic [15:0] QUOTIENT;
  logic [7:0]  REMAINDER;
  logic        BUSY;
  logic        DONE;
  logic        DIVERR;

  int total = 0;
  int bad   = 0;

  seq_divider #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .START     (START),
    .DIVIDEND  (DIVIDEND),
    .DIVISOR   (DIVISOR),
    .QUOTIENT  (QUOTIENT),
    .REMAINDER (REMAINDER),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .DIVERR    (DIVERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse START for one edge, then wait (bounded) for DONE; inputs change
  // and outputs are sampled on the falling edge.
  task automatic run_div(input logic [15:0] a, input logic [7:0] b,
                         output int lat, output int busy_n);
    DIVIDEND = a;
    DIVISOR  = b;
    START    = 1'b1;
    @(negedge CLK);
    START  = 1'b0;
    lat    = 0;
    busy_n = 0;
    while (DONE !== 1'b1 && lat < 40) begin
      if (BUSY === 1'b1) busy_n++;
      @(negedge CLK);
      lat++;
    end
  endtask

  initial begin : stim
    int lat;
    int busy_n;
    int cyc;
    int last_done;
    logic saw_done;
    logic [15:0] a;
    logic [7:0]  b;

    RESET_N  = 1'b0;
    START    = 1'b0;
    DIVIDEND = '0;
    DIVISOR  = '0;
    repeat (2) @(negedge CLK);
    check("rst_q", QUOTIENT, 0);
    check("rst_r", REMAINDER, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_diverr", DIVERR, 0);
    RESET_N = 1'b1;
    @(negedge CLK);

    // 100 / 7 = 14 r 2
    run_div(16'h0064, 8'h07, lat, busy_n);
    check("t1_done", DONE, 1);
    check("t1_lat", lat, 17);
    check("t1_busy_cycles", busy_n, 17);
    check("t1_busy_at_done", BUSY, 0);
    check("t1_q", QUOTIENT, 16'h000E);
    check("t1_r", REMAINDER, 8'h02);
    check("t1_diverr", DIVERR, 0);
    @(negedge CLK);
    check("t1_done_pulse", DONE, 0);
    check("t1_q_hold", QUOTIENT, 16'h000E);

    run_div(16'hFFFF, 8'h01, lat, busy_n);
    check("t2a_done", DONE, 1);
    check("t2a_q", QUOTIENT, 16'hFFFF);
    check("t2a_r", REMAINDER, 8'h00);
    run_div(16'hFFFF, 8'hFF, lat, busy_n);
    check("t2b_done", DONE, 1);
    check("t2b_q", QUOTIENT, 16'h0101);
    check("t2b_r", REMAINDER, 8'h00);

    run_div(16'h0005, 8'h09, lat, busy_n);
    check("t3a_done", DONE, 1);
    check("t3a_q", QUOTIENT, 16'h0000);
    check("t3a_r", REMAINDER, 8'h05);
    run_div(16'h0000, 8'h03, lat, busy_n);
    check("t3b_done", DONE, 1);
    check("t3b_q", QUOTIENT, 16'h0000);
    check("t3b_r", REMAINDER, 8'h00);

    // Divide by zero: immediate error post, no iteration
    run_div(16'h1234, 8'h00, lat, busy_n);
    check("dz_lat", lat, 0);
    check("dz_done", DONE, 1);
    check("dz_busy", BUSY, 0);
    check("dz_busy_cycles", busy_n, 0);
    check("dz_diverr", DIVERR, 1);
    check("dz_q", QUOTIENT, 16'hFFFF);
    check("dz_r", REMAINDER, 8'hFF);
    @(negedge CLK);
    check("dz_done_pulse", DONE, 0);
    check("dz_diverr_hold", DIVERR, 1);
    run_div(16'h0064, 8'h07, lat, busy_n);
    check("dz2_done", DONE, 1);
    check("dz2_diverr", DIVERR, 0);
    check("dz2_q", QUOTIENT, 16'h000E);
    check("dz2_r", REMAINDER, 8'h02);

    // START while busy is ignored
    DIVIDEND = 16'h0064;
    DIVISOR  = 8'h07;
    START    = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (4) @(negedge CLK);
    DIVIDEND = 16'h00FF;
    DIVISOR  = 8'h10;
    START    = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    lat = 5;
    while (DONE !== 1'b1 && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
    check("ign_done", DONE, 1);
    check("ign_lat", lat, 17);
    check("ign_q", QUOTIENT, 16'h000E);
    check("ign_r", REMAINDER, 8'h02);
    repeat (2) @(negedge CLK);
    check("ign_no_second", BUSY, 0);

    // Reset mid-operation
    DIVIDEND = 16'h4321;
    DIVISOR  = 8'h05;
    START    = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (7) @(negedge CLK);
    check("mid_busy_pre", BUSY, 1);
    RESET_N = 1'b0;
    #1;
    check("mid_q", QUOTIENT, 0);
    check("mid_r", REMAINDER, 0);
    check("mid_busy", BUSY, 0);
    check("mid_done", DONE, 0);
    check("mid_diverr", DIVERR, 0);
    @(negedge CLK);
    RESET_N  = 1'b1;
    saw_done = 1'b0;
    repeat (25) begin
      @(negedge CLK);
      if (DONE === 1'b1 || BUSY === 1'b1) saw_done = 1'b1;
    end
    check("mid_no_done", saw_done, 0);

    // Sweep with START held high: back-to-back results every 18 cycles
    a = 16'($urandom_range(65535));
    b = 8'($urandom_range(255, 1));
    DIVIDEND  = a;
    DIVISOR   = b;
    START     = 1'b1;
    cyc       = 0;
    last_done = -1;
    for (int i = 0; i < 1000; i++) begin
      lat = 0;
      @(negedge CLK);
      cyc++;
      while (DONE !== 1'b1 && lat < 40) begin
        @(negedge CLK);
        cyc++;
        lat++;
      end
      check("rnd_done", DONE, 1);
      check("rnd_q", QUOTIENT, 32'(a / b));
      check("rnd_r", REMAINDER, 32'(a % b));
      check("rnd_r_lt_d", (REMAINDER < b), 1);
      if (last_done >= 0) check("rnd_spacing", cyc - last_done, 18);
      last_done = cyc;
      if (DONE !== 1'b1) break;
      if (i == 999) begin
        START = 1'b0;
      end else begin
        a = 16'($urandom_range(65535));
        b = 8'($urandom_range(255, 1));
        DIVIDEND = a;
        DIVISOR  = b;
      end
    end
    START = 1'b0;
    repeat (3) @(negedge CLK);
    check("end_idle", BUSY, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
